// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between adjacent Y86 pipeline stages.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 211
);
   logic              stall_i;
   logic              bubble_i;
   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;

   modport master (
      output stall_i, bubble_i, valid_i, data_i,
      input  valid_o, data_o
   );

   modport slave (
      input  stall_i, bubble_i, valid_i, data_i,
      output valid_o, data_o
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic Y86 pipeline-stage register with stall/bubble control and stall-run timeout.
// Optional saturating performance counters when PIPE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W           = 211,
   parameter logic [DATA_W-1:0] BUBBLE_VAL       = '0,
   parameter logic [DATA_W-1:0] BUBBLE_KEEP_MASK = '0,
   parameter int unsigned       STALL_MAX        = 16,
   parameter int unsigned       CNT_W            = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   pipe_stage_reg_if.slave      pif,
   output logic [CNT_W-1:0]     stall_run_o,
   output logic                 stall_timeout_o
`ifdef PIPE_PERF_CNT_EN
   ,
   input  logic                 perf_clr_i,
   output logic [CNT_W-1:0]     perf_stall_o,
   output logic [CNT_W-1:0]     perf_bubble_o,
   output logic [CNT_W-1:0]     perf_load_o
`endif
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  run_q, run_d;
   logic              to_q, to_d;
   logic              stalled;

   always_comb begin
      stalled = pif.stall_i & ~pif.bubble_i;
      data_d  = data_q;
      valid_d = valid_q;
      if (pif.bubble_i) begin
         // Masked fields (e.g. stat) keep flowing so exceptions survive a bubble.
         data_d  = (pif.data_i & BUBBLE_KEEP_MASK) | (BUBBLE_VAL & ~BUBBLE_KEEP_MASK);
         valid_d = 1'b0;
      end else if (!pif.stall_i) begin
         data_d  = pif.data_i;
         valid_d = pif.valid_i;
      end
      run_d = stalled ? sat_inc(run_q) : '0;
      to_d  = (run_d >= CNT_W'(STALL_MAX));
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q  <= BUBBLE_VAL;
         valid_q <= 1'b0;
         run_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         run_q   <= run_d;
         to_q    <= to_d;
      end
   end

   assign pif.data_o      = data_q;
   assign pif.valid_o     = valid_q;
   assign stall_run_o     = run_q;
   assign stall_timeout_o = to_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] pstall_q, pbubble_q, pload_q;
   logic [CNT_W-1:0] pstall_d, pbubble_d, pload_d;

   always_comb begin
      pstall_d  = pstall_q;
      pbubble_d = pbubble_q;
      pload_d   = pload_q;
      if (perf_clr_i) begin
         pstall_d  = '0;
         pbubble_d = '0;
         pload_d   = '0;
      end else begin
         if (stalled)      pstall_d  = sat_inc(pstall_q);
         if (pif.bubble_i) pbubble_d = sat_inc(pbubble_q);
         if (!pif.bubble_i && !pif.stall_i && pif.valid_i) pload_d = sat_inc(pload_q);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pstall_q  <= '0;
         pbubble_q <= '0;
         pload_q   <= '0;
      end else begin
         pstall_q  <= pstall_d;
         pbubble_q <= pbubble_d;
         pload_q   <= pload_d;
      end
   end

   assign perf_stall_o  = pstall_q;
   assign perf_bubble_o = pbubble_q;
   assign perf_load_o   = pload_q;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline-stage register for the five-stage Y86 pipeline. It replaces the hand-written per-stage registers (F/D, D/E, E/M, M/W) with one block: a packed payload, a valid bit, a stall/bubble priority scheme, and a per-bit mask of fields that still load during a bubble. It also detects stalls that last too long, so pipeline deadlock is visible in simulation and on a status line.

Parameters:
DATA_W, 211, width of packed payload (decode-stage default: stat 3 + pc 64 + icode 4 + ifun 4 + rA 4 + rB 4 + valC 64 + valP 64)
BUBBLE_VAL, {DATA_W{1'b0}}, payload value injected on bubble and on reset (caller encodes NOP icode, rA/rB = 4'hf)
BUBBLE_KEEP_MASK, {DATA_W{1'b0}}, bit=1: that payload bit loads from data_i even during a bubble (used for stat)
STALL_MAX, 16, consecutive-stall threshold for the timeout flag; legal range 1..2^CNT_W-1
CNT_W, 8, width of stall-run and performance counters

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous reset, active low
stall_i  input  1  hold current contents
bubble_i  input  1  inject bubble (higher priority than stall_i)
valid_i  input  1  upstream stage holds a real instruction
data_i  input  DATA_W  packed upstream payload
valid_o  output  1  register holds a real instruction
data_o  output  DATA_W  registered payload
stall_run_o  output  CNT_W  current count of consecutive stalled cycles
stall_timeout_o  output  1  registered; high while stall_run_o >= STALL_MAX

Behaviour:
- Reset (rst_n_i low, asynchronous, any cycle):
  - data_o = BUBBLE_VAL, valid_o = 0, stall_run_o = 0, stall_timeout_o = 0, perf counters = 0.
  - Reset asserted mid-stall or mid-bubble overrides everything immediately.
- Register update at each posedge, priority order:
  - bubble_i = 1: data_o = (data_i & BUBBLE_KEEP_MASK) | (BUBBLE_VAL & ~BUBBLE_KEEP_MASK); valid_o = 0. Applies whatever the value of stall_i.
  - else stall_i = 1: data_o and valid_o hold.
  - else (load): data_o = data_i, valid_o = valid_i.
- Latency: 1 cycle, data_i to data_o.
- There is no combinational path from any input to any output.
- Stall-run counter:
  - A cycle counts as stalled when stall_i = 1 and bubble_i = 0.
  - Stalled cycle: stall_run_o increments, saturating at 2^CNT_W-1.
  - Any other cycle: stall_run_o clears to 0.
  - stall_timeout_o is registered from the next value of stall_run_o, so it rises on the same edge on which stall_run_o reaches STALL_MAX.
  - It falls on the first non-stalled edge.
- Simultaneous stall_i and bubble_i: treated as a bubble; the stall run resets.
- Holding in a stall with valid_o = 0 is legal and still counts toward the timeout.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs perf_stall_o [CNT_W-1:0], perf_bubble_o [CNT_W-1:0] and perf_load_o [CNT_W-1:0].
  - Each is a saturating count of stalled, bubbled and loaded-with-valid_i = 1 cycles since reset.
  - Input perf_clr_i (1 bit) clears all three synchronously; a concurrent event in that cycle is not counted.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release with defaults -> data_o = 0, valid_o = 0, stall_run_o = 0. Assert rst_n_i low mid-stall with stall_run_o = 5 -> all outputs return to reset values with no clock edge.
- Load: valid_i = 1, data_i = 211'h1234, stall_i = 0, bubble_i = 0 -> after one edge, data_o = 211'h1234 and valid_o = 1.
- Bubble with BUBBLE_KEEP_MASK = low 3 bits set, BUBBLE_VAL = 211'h10 (NOP icode field), data_i low bits = 3'b010 -> data_o = 211'h12, valid_o = 0.
- Stall and bubble both high with data_i = 211'hABCD -> bubble result; stall_run_o = 0.
- STALL_MAX = 4, stall_i held high for 6 cycles -> stall_run_o counts 1..6; stall_timeout_o rises on the 4th edge; data_o unchanged throughout. Drop stall_i -> stall_run_o = 0 and timeout = 0 after one edge.
- PIPE_PERF_CNT_EN defined, CNT_W = 4:
  - 20 stalled cycles -> perf_stall_o saturates at 15.
  - perf_clr_i pulsed in a cycle with bubble_i = 1 -> perf_bubble_o = 0 the next cycle.
